// File: rtl/kernel_kcore_start_fifo_ex.sv
// Parametrised shift-register handshake FIFO carrying start tokens between kcore dataflow processes.
// Registered status flags (occupancy, almost-full/empty) plus sticky overflow/underflow debug flags.
module kernel_kcore_start_fifo_ex #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_clear,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_COUNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_COUNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_COUNT   = (ADDR_WIDTH+1)'(1);
  localparam logic                AF_AT_RESET = (AF_LEVEL == 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   next_count;
  logic [ADDR_WIDTH:0]   top_idx;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr;
  logic                  rd;

  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  assign wr     = wr_req & if_full_n;
  assign rd     = rd_req & if_empty_n;

  // A simultaneous push and pop leaves the oldest entry at the same index after the shift.
  always_comb begin
    next_count = if_count;
    if (if_clear)
      next_count = '0;
    else if (wr && !rd)
      next_count = if_count + ONE_COUNT;
    else if (rd && !wr)
      next_count = if_count - ONE_COUNT;
  end

  // Storage is intentionally not reset; only the occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (wr && !if_clear) begin
      for (int i = DEPTH - 1; i > 0; i--)
        mem[i] <= mem[i-1];
      mem[0] <= if_din;
    end
  end

  assign top_idx = if_count - ONE_COUNT;
  assign if_dout = (if_count != '0) ? mem[top_idx[ADDR_WIDTH-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_count        <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= AF_AT_RESET;
      if_almost_empty <= 1'b1;
      if_overflow     <= 1'b0;
      if_underflow    <= 1'b0;
    end else begin
      if_count        <= next_count;
      if_empty_n      <= (next_count != '0);
      if_full_n       <= (next_count != FULL_COUNT);
      if_almost_full  <= (next_count >= AF_COUNT);
      if_almost_empty <= (next_count <= AE_COUNT);
      if (if_clear) begin
        if_overflow  <= 1'b0;
        if_underflow <= 1'b0;
      end else begin
        if (wr_req && !if_full_n)
          if_overflow <= 1'b1;
        if (rd_req && !if_empty_n)
          if_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_kcore_start_fifo_ex.sv
// Scoreboard bench for kernel_kcore_start_fifo_ex: a queue-based reference model predicts
// popped data and status; a negedge monitor compares whenever the DUT completes a pop.
module tb_kernel_kcore_start_fifo_ex;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int AW = 3;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_clear = 1'b0;
  logic          if_write_ce = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b0;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   if_count;
  logic          if_almost_full;
  logic          if_almost_empty;
  logic          if_overflow;
  logic          if_underflow;

  kernel_kcore_start_fifo_ex #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .reset(reset), .if_clear(if_clear),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_count(if_count), .if_almost_full(if_almost_full), .if_almost_empty(if_almost_empty),
    .if_overflow(if_overflow), .if_underflow(if_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // Reference model: FIFO contents as a queue, plus sticky error bits.
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  bit            model_unf = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the outcome, and advance to 1 time unit after the edge.
  task automatic applyStimulus(input bit clr, input bit wce, input bit w, input logic [DW-1:0] d,
                               input bit rce, input bit r);
    bit full, empty, acc_wr, acc_rd;
    if_clear = clr; if_write_ce = wce; if_write = w; if_din = d;
    if_read_ce = rce; if_read = r;
    full   = (model_q.size() == DEPTH);
    empty  = (model_q.size() == 0);
    acc_wr = w && wce && !full;
    acc_rd = r && rce && !empty;
    if (!clr && acc_rd) exp_q.push_back(model_q[0]);
    @(posedge clk);
    #1;
    if (clr) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      if (w && wce && full) model_ovf = 1'b1;
      if (r && rce && empty) model_unf = 1'b1;
      if (acc_rd) void'(model_q.pop_front());
      if (acc_wr) model_q.push_back(d);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, 32'(if_count), 32'd0);
    checkOutput({tag, "_empty_n"}, 32'(if_empty_n), 32'd0);
    checkOutput({tag, "_full_n"}, 32'(if_full_n), 32'd1);
    checkOutput({tag, "_almost_empty"}, 32'(if_almost_empty), 32'd1);
    checkOutput({tag, "_almost_full"}, 32'(if_almost_full), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(if_overflow), 32'd0);
    checkOutput({tag, "_underflow"}, 32'(if_underflow), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted pop and tracks status against the model.
  always @(negedge clk) begin
    if (checking) begin
      int n;
      n = model_q.size();
      if (if_read && if_read_ce && if_empty_n && !if_clear) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pop_unexpected: got dout %0h required no pop at %0t", if_dout, $time);
        end else begin
          checkOutput("pop_data", 32'(if_dout), 32'(exp_q.pop_front()));
        end
      end
      checkOutput("count", 32'(if_count), 32'(n));
      checkOutput("empty_n", 32'(if_empty_n), 32'(n != 0));
      checkOutput("full_n", 32'(if_full_n), 32'(n != DEPTH));
      checkOutput("almost_full", 32'(if_almost_full), 32'(n >= AF));
      checkOutput("almost_empty", 32'(if_almost_empty), 32'(n <= AE));
      checkOutput("overflow", 32'(if_overflow), 32'(model_ovf));
      checkOutput("underflow", 32'(if_underflow), 32'(model_unf));
      checkOutput("dout_head", 32'(if_dout), (n != 0) ? 32'(model_q[0]) : 32'd0);
    end
  end

  initial begin
    logic [DW-1:0] d;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    checking = 1'b1;

    // Fill to full, then one more write to trip overflow.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 17);
      applyStimulus(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
    end
    checkOutput("t1_full_count", 32'(if_count), 32'd5);
    checkOutput("t1_full_n", 32'(if_full_n), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    checkOutput("t1_overflow", 32'(if_overflow), 32'd1);
    checkOutput("t1_count_held", 32'(if_count), 32'd5);

    // Read plus write when full: only the read proceeds.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    checkOutput("full_rw_count", 32'(if_count), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);

    // Drain: expected 0x22..0x55 then 0x55, then an extra pop for underflow.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t2_empty_n", 32'(if_empty_n), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t2_underflow", 32'(if_underflow), 32'd1);

    // Simultaneous read+write at count 2; read+write when empty accepts only the write.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("t3_count", 32'(if_count), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Single write into empty: visible the following cycle, no bypass.
    checkOutput("t4_empty_before", 32'(if_empty_n), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("t4_empty_n", 32'(if_empty_n), 32'd1);
    checkOutput("t4_dout", 32'(if_dout), 32'hA5);

    // Build count 3 with both errors, then clear with a coincident write.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB6, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC7, 1'b0, 1'b0);
    checkOutput("t5_count3", 32'(if_count), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hD8, 1'b0, 1'b0);
    checkResetState("t5_clear");

    // Async reset between edges at count 4.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("t6_count4", 32'(if_count), 32'd4);
    #1;
    reset = 1'b1;
    #1;
    checkResetState("t6_async");
    #1;
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hE9, 1'b0, 1'b0);
    checkOutput("t6_resume_dout", 32'(if_dout), 32'hE9);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end
    idleCycle();
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
